// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU control path: FSM states, instruction
// opcodes, ALU operation codes (also used by the alu module) and the
// control-strobe bundle produced by the microsequencer decoder.
package cpu_pkg;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [2:0] {
        FETCH0,
        FETCH1,
        DECODE,
        OPND0,
        OPND1,
        EXEC,
        ALU,
        HALT
    } state_t;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LDA   = 4'h1,
        OP_LDB   = 4'h2,
        OP_STA   = 4'h3,
        OP_ADD   = 4'h4,
        OP_SUB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_XOR   = 4'h8,
        OP_JMP   = 4'h9,
        OP_JZ    = 4'hA,
        OP_JC    = 4'hB,
        OP_RSV_C = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_HLT   = 4'hF
    } opcode_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h4;

    // Datapath control strobes; polarity follows the port each field drives.
    typedef struct packed {
        logic a_rdn;
        logic a_wrtn;
        logic b_rdn;
        logic b_wrtn;
        logic ir_wrtn;
        logic mar_wrtn;
        logic ram_rdn;
        logic ram_wrtn;
        logic pc_cnt;
        logic pc_den;
        logic pc_din;
        logic alu_sel;
        logic alu_flag_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        a_rdn:        1'b1,
        a_wrtn:       1'b1,
        b_rdn:        1'b1,
        b_wrtn:       1'b1,
        ir_wrtn:      1'b1,
        mar_wrtn:     1'b1,
        ram_rdn:      1'b1,
        ram_wrtn:     1'b1,
        pc_cnt:       1'b1,
        pc_den:       1'b0,
        pc_din:       1'b0,
        alu_sel:      1'b0,
        alu_flag_sel: 1'b0
    };

    function automatic logic is_alu_op(input opcode_t op);
        return op inside {[OP_ADD:OP_XOR]};
    endfunction

    function automatic logic is_mem_op(input opcode_t op);
        return op inside {OP_LDA, OP_LDB, OP_STA};
    endfunction

    function automatic logic [ALU_OP_W-1:0] alu_code(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decoder: maps (state, opcode) to the datapath control
// bundle. Every state drives at most one bus source.
//   i_state  current FSM state
//   i_opcode opcode in effect (live IR in DECODE, latched copy elsewhere)
//   i_run    fetch enable, already gated by reset
//   i_taken  conditional branch condition, meaningful in DECODE only
//   o_ctrl   strobe bundle
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t  i_state,
    input  opcode_t i_opcode,
    input  logic    i_run,
    input  logic    i_taken,
    output ctrl_t   o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_state)
            FETCH0: begin
                if (i_run) begin
                    o_ctrl.pc_den   = 1'b1;
                    o_ctrl.mar_wrtn = 1'b0;
                end
            end
            FETCH1: begin
                o_ctrl.ram_rdn = 1'b0;
                o_ctrl.ir_wrtn = 1'b0;
                o_ctrl.pc_cnt  = 1'b0;
            end
            DECODE: begin
                // Untaken branch steps the PC past its operand byte.
                if ((i_opcode == OP_JZ || i_opcode == OP_JC) && !i_taken) begin
                    o_ctrl.pc_cnt = 1'b0;
                end
            end
            OPND0: begin
                o_ctrl.pc_den   = 1'b1;
                o_ctrl.mar_wrtn = 1'b0;
            end
            OPND1: begin
                o_ctrl.ram_rdn = 1'b0;
                if (is_mem_op(i_opcode)) begin
                    o_ctrl.mar_wrtn = 1'b0;
                    o_ctrl.pc_cnt   = 1'b0;
                end else begin
                    o_ctrl.pc_din = 1'b1;
                end
            end
            EXEC: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl.ram_rdn = 1'b0;
                        o_ctrl.a_wrtn  = 1'b0;
                    end
                    OP_LDB: begin
                        o_ctrl.ram_rdn = 1'b0;
                        o_ctrl.b_wrtn  = 1'b0;
                    end
                    OP_STA: begin
                        o_ctrl.a_rdn    = 1'b0;
                        o_ctrl.ram_wrtn = 1'b0;
                    end
                    default: ;
                endcase
            end
            ALU: begin
                o_ctrl.alu_sel      = 1'b1;
                o_ctrl.a_wrtn       = 1'b0;
                o_ctrl.alu_flag_sel = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Microsequencer for the 8-bit CPU: fetches, decodes and executes one
// instruction at a time and drives every datapath control strobe.
//   i_clk/i_rstn   clock, async active-low reset
//   i_run          allow a new fetch
//   i_ir_data      IR contents, opcode in [7:4]
//   i_zr/i_co      ALU flags, sampled in DECODE
//   i_pc_of        PC overflow; fatal when coinciding with a PC count
//   o_*            datapath strobes, ALU opcode/carry-in, halt/fault status
module cpu_control_sequencer
    import cpu_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_run,
    input  logic [7:0]          i_ir_data,
    input  logic                i_zr,
    input  logic                i_co,
    input  logic                i_pc_of,
    output logic                o_a_rdn,
    output logic                o_a_wrtn,
    output logic                o_b_rdn,
    output logic                o_b_wrtn,
    output logic                o_ir_wrtn,
    output logic                o_mar_wrtn,
    output logic                o_ram_rdn,
    output logic                o_ram_wrtn,
    output logic                o_pc_cnt,
    output logic                o_pc_den,
    output logic                o_pc_din,
    output logic [ALU_OP_W-1:0] o_alu_opcode,
    output logic                o_cin,
    output logic                o_alu_sel,
    output logic                o_alu_flag_sel,
    output logic                o_halted,
    output logic                o_fault
);

    state_t                r_state;
    state_t                w_next;
    opcode_t               r_opcode;
    opcode_t               w_opcode;
    logic [ALU_OP_W-1:0]   r_alu_op;
    logic                  r_cin;
    logic                  r_fault;
    logic                  w_run;
    logic                  w_taken;
    logic                  w_overflow;
    logic                  w_unused_ir;
    ctrl_t                 w_ctrl;

    // Operand nibble is consumed by the datapath, not here.
    assign w_unused_ir = ^i_ir_data[3:0];

    // Holding reset keeps FETCH0 quiet even with i_run high.
    assign w_run      = i_run & i_rstn;
    assign w_opcode   = (r_state == DECODE) ? opcode_t'(i_ir_data[7:4]) : r_opcode;
    assign w_taken    = ((w_opcode == OP_JZ) && i_zr) || ((w_opcode == OP_JC) && i_co);
    assign w_overflow = ~w_ctrl.pc_cnt & i_pc_of;

    cpu_ctrl_decode u_decode (
        .i_state  (r_state),
        .i_opcode (w_opcode),
        .i_run    (w_run),
        .i_taken  (w_taken),
        .o_ctrl   (w_ctrl)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= FETCH0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a PC overflow on a counting cycle overrides everything.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH0: if (w_run) w_next = FETCH1;
            FETCH1: w_next = DECODE;
            DECODE: begin
                case (w_opcode)
                    OP_LDA, OP_LDB, OP_STA, OP_JMP:        w_next = OPND0;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w_next = ALU;
                    OP_JZ, OP_JC:                          w_next = w_taken ? OPND0 : FETCH0;
                    OP_HLT:                                w_next = HALT;
                    default:                               w_next = FETCH0;
                endcase
            end
            OPND0:   w_next = OPND1;
            OPND1:   w_next = is_mem_op(r_opcode) ? EXEC : FETCH0;
            EXEC:    w_next = FETCH0;
            ALU:     w_next = FETCH0;
            HALT:    w_next = HALT;
            default: w_next = FETCH0;
        endcase
        if (w_overflow) begin
            w_next = HALT;
        end
    end

    // Opcode latch, held ALU operation and sticky fault flag.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_opcode <= OP_NOP;
            r_alu_op <= '0;
            r_cin    <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state == DECODE) begin
                r_opcode <= w_opcode;
                if (is_alu_op(w_opcode)) begin
                    r_alu_op <= alu_code(w_opcode);
                    r_cin    <= (w_opcode == OP_SUB);
                end
            end
            if (w_overflow) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Output mapping.
    always_comb begin
        o_a_rdn        = w_ctrl.a_rdn;
        o_a_wrtn       = w_ctrl.a_wrtn;
        o_b_rdn        = w_ctrl.b_rdn;
        o_b_wrtn       = w_ctrl.b_wrtn;
        o_ir_wrtn      = w_ctrl.ir_wrtn;
        o_mar_wrtn     = w_ctrl.mar_wrtn;
        o_ram_rdn      = w_ctrl.ram_rdn;
        o_ram_wrtn     = w_ctrl.ram_wrtn;
        o_pc_cnt       = w_ctrl.pc_cnt;
        o_pc_den       = w_ctrl.pc_den;
        o_pc_din       = w_ctrl.pc_din;
        o_alu_sel      = w_ctrl.alu_sel;
        o_alu_flag_sel = w_ctrl.alu_flag_sel;
        o_alu_opcode   = r_alu_op;
        o_cin          = r_cin;
        o_halted       = (r_state == HALT);
        o_fault        = r_fault;
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Testbench for cpu_control_sequencer: latency table, hand-written corner
// sequences and randomized instruction streams against an instruction-level
// model of the expected strobe pattern per cycle.
module tb_cpu_control_sequencer;
    import cpu_pkg::*;

    typedef logic [12:0] vec_t;
    typedef vec_t vq_t[$];

    // Active-high view of each strobe, independent of port polarity.
    localparam vec_t A_RD   = 13'h0001;
    localparam vec_t A_WR   = 13'h0002;
    localparam vec_t B_RD   = 13'h0004;
    localparam vec_t B_WR   = 13'h0008;
    localparam vec_t IR_WR  = 13'h0010;
    localparam vec_t MAR_WR = 13'h0020;
    localparam vec_t RAM_RD = 13'h0040;
    localparam vec_t RAM_WR = 13'h0080;
    localparam vec_t PC_CNT = 13'h0100;
    localparam vec_t PC_DEN = 13'h0200;
    localparam vec_t PC_DIN = 13'h0400;
    localparam vec_t AL_SEL = 13'h0800;
    localparam vec_t FLAG   = 13'h1000;
    localparam vec_t IDLE   = 13'h0000;
    localparam vec_t PC2MAR = PC_DEN | MAR_WR;
    localparam vec_t FETCHI = RAM_RD | IR_WR | PC_CNT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] ir = 8'h00;
    logic       zr = 1'b0;
    logic       co = 1'b0;
    logic       pc_of = 1'b0;

    logic       o_a_rdn, o_a_wrtn, o_b_rdn, o_b_wrtn, o_ir_wrtn, o_mar_wrtn;
    logic       o_ram_rdn, o_ram_wrtn, o_pc_cnt, o_pc_den, o_pc_din;
    logic [3:0] o_alu_opcode;
    logic       o_cin, o_alu_sel, o_alu_flag_sel, o_halted, o_fault;

    vec_t       obs_v;
    logic       obs_halted, obs_fault, obs_cin;
    logic [3:0] obs_alu;
    int         n_checks = 0;
    int         n_err = 0;

    cpu_control_sequencer dut (
        .i_clk          (clk),
        .i_rstn         (rst_n),
        .i_run          (run),
        .i_ir_data      (ir),
        .i_zr           (zr),
        .i_co           (co),
        .i_pc_of        (pc_of),
        .o_a_rdn        (o_a_rdn),
        .o_a_wrtn       (o_a_wrtn),
        .o_b_rdn        (o_b_rdn),
        .o_b_wrtn       (o_b_wrtn),
        .o_ir_wrtn      (o_ir_wrtn),
        .o_mar_wrtn     (o_mar_wrtn),
        .o_ram_rdn      (o_ram_rdn),
        .o_ram_wrtn     (o_ram_wrtn),
        .o_pc_cnt       (o_pc_cnt),
        .o_pc_den       (o_pc_den),
        .o_pc_din       (o_pc_din),
        .o_alu_opcode   (o_alu_opcode),
        .o_cin          (o_cin),
        .o_alu_sel      (o_alu_sel),
        .o_alu_flag_sel (o_alu_flag_sel),
        .o_halted       (o_halted),
        .o_fault        (o_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t active();
        return {o_alu_flag_sel, o_alu_sel, o_pc_din, o_pc_den, ~o_pc_cnt,
                ~o_ram_wrtn, ~o_ram_rdn, ~o_mar_wrtn, ~o_ir_wrtn,
                ~o_b_wrtn, ~o_b_rdn, ~o_a_wrtn, ~o_a_rdn};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // One clock: sample mid-cycle, check bus/load invariants, advance past the edge.
    task automatic tick();
        int drivers;
        @(negedge clk);
        obs_v      = active();
        obs_halted = o_halted;
        obs_fault  = o_fault;
        obs_cin    = o_cin;
        obs_alu    = o_alu_opcode;
        drivers    = $countones({obs_v[0], obs_v[2], obs_v[6], obs_v[9], obs_v[11]});
        check("bus_single_driver", 32'(drivers <= 1), 32'd1);
        check("pc_load_vs_count", 32'(obs_v[10] & obs_v[8]), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        pc_of = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Expected per-cycle strobes for one whole instruction.
    function automatic void expand(input logic [3:0] op, input logic z, input logic c, output vq_t q);
        q = {};
        q.push_back(PC2MAR);
        q.push_back(FETCHI);
        if (op inside {4'h1, 4'h2, 4'h3}) begin
            q.push_back(IDLE);
            q.push_back(PC2MAR);
            q.push_back(RAM_RD | MAR_WR | PC_CNT);
            q.push_back(op == 4'h1 ? (RAM_RD | A_WR) :
                        op == 4'h2 ? (RAM_RD | B_WR) : (A_RD | RAM_WR));
        end else if (op inside {[4'h4:4'h8]}) begin
            q.push_back(IDLE);
            q.push_back(AL_SEL | A_WR | FLAG);
        end else if (op == 4'h9 || (op == 4'hA && z) || (op == 4'hB && c)) begin
            q.push_back(IDLE);
            q.push_back(PC2MAR);
            q.push_back(RAM_RD | PC_DIN);
        end else if (op == 4'hA || op == 4'hB) begin
            q.push_back(PC_CNT);
        end else begin
            q.push_back(IDLE);
        end
    endfunction

    function automatic logic [3:0] alu_exp(input logic [3:0] op);
        case (op)
            4'h5:    return ALU_SUB;
            4'h6:    return ALU_AND;
            4'h7:    return ALU_OR;
            4'h8:    return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

    // Run one instruction with fixed inputs and compare every cycle with the model.
    task automatic run_instr(input string nm, input logic [7:0] instr, input logic z, input logic c);
        vq_t q;
        ir = instr;
        zr = z;
        co = c;
        run = 1'b1;
        expand(instr[7:4], z, c, q);
        for (int i = 0; i < q.size(); i++) begin
            tick();
            check(nm, obs_v, q[i]);
        end
    endtask

    typedef struct {
        logic [7:0] ir;
        logic       z;
        logic       c;
        int         lat;
        logic       is_alu;
        logic [3:0] aop;
        logic       cin;
    } lat_vec_t;

    lat_vec_t tbl[15];

    initial begin
        vq_t        q;
        logic [3:0] op;
        logic       z, c;
        logic [3:0] exp_alu;
        logic       exp_cin;
        int         found, cyc, gap;
        logic [3:0] alu_at4;
        logic       cin_at4;

        tbl[0]  = '{8'h00, 1'b0, 1'b0, 3, 1'b0, 4'h0,    1'b0};
        tbl[1]  = '{8'h18, 1'b0, 1'b0, 6, 1'b0, 4'h0,    1'b0};
        tbl[2]  = '{8'h28, 1'b0, 1'b0, 6, 1'b0, 4'h0,    1'b0};
        tbl[3]  = '{8'h39, 1'b0, 1'b0, 6, 1'b0, 4'h0,    1'b0};
        tbl[4]  = '{8'h40, 1'b0, 1'b0, 4, 1'b1, ALU_ADD, 1'b0};
        tbl[5]  = '{8'h50, 1'b0, 1'b0, 4, 1'b1, ALU_SUB, 1'b1};
        tbl[6]  = '{8'h60, 1'b0, 1'b0, 4, 1'b1, ALU_AND, 1'b0};
        tbl[7]  = '{8'h70, 1'b0, 1'b0, 4, 1'b1, ALU_OR,  1'b0};
        tbl[8]  = '{8'h80, 1'b0, 1'b0, 4, 1'b1, ALU_XOR, 1'b0};
        tbl[9]  = '{8'h90, 1'b0, 1'b0, 5, 1'b0, 4'h0,    1'b0};
        tbl[10] = '{8'hA0, 1'b1, 1'b0, 5, 1'b0, 4'h0,    1'b0};
        tbl[11] = '{8'hA0, 1'b0, 1'b1, 3, 1'b0, 4'h0,    1'b0};
        tbl[12] = '{8'hB0, 1'b0, 1'b1, 5, 1'b0, 4'h0,    1'b0};
        tbl[13] = '{8'hB0, 1'b1, 1'b0, 3, 1'b0, 4'h0,    1'b0};
        tbl[14] = '{8'hD0, 1'b1, 1'b1, 3, 1'b0, 4'h0,    1'b0};

        // Reset, then idle with i_run low: everything inactive, FSM parked.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_strobes", obs_v, IDLE);
            check("idle_halted", 32'(obs_halted), 32'd0);
            check("idle_fault", 32'(obs_fault), 32'd0);
            check("idle_aluop", 32'(obs_alu), 32'd0);
            check("idle_cin", 32'(obs_cin), 32'd0);
        end
        run = 1'b1;
        tick();
        check("first_fetch", obs_v, PC2MAR);

        // Latency and ALU control per opcode.
        foreach (tbl[k]) begin
            do_reset();
            ir = tbl[k].ir;
            zr = tbl[k].z;
            co = tbl[k].c;
            run = 1'b1;
            found = 0;
            cyc = 0;
            alu_at4 = 4'h0;
            cin_at4 = 1'b0;
            while (found == 0 && cyc < 20) begin
                cyc++;
                tick();
                if (cyc == 4) begin
                    alu_at4 = obs_alu;
                    cin_at4 = obs_cin;
                end
                if (cyc > 2 && obs_v == FETCHI) found = cyc;
            end
            check($sformatf("latency_ir%02h", tbl[k].ir), 32'(found - 2), 32'(tbl[k].lat));
            if (tbl[k].is_alu) begin
                check($sformatf("aluop_ir%02h", tbl[k].ir), 32'(alu_at4), 32'(tbl[k].aop));
                check($sformatf("cin_ir%02h", tbl[k].ir), 32'(cin_at4), 32'(tbl[k].cin));
            end
        end

        // LDA 8 then STA 9: A load in cycle 6, RAM write in cycle 12.
        do_reset();
        run_instr("lda_cycle", 8'h10, 1'b0, 1'b0);
        check("lda_a_load_c6", obs_v, RAM_RD | A_WR);
        run_instr("sta_cycle", 8'h30, 1'b0, 1'b0);
        check("sta_ram_write_c12", obs_v, A_RD | RAM_WR);

        // JZ taken and untaken.
        do_reset();
        run_instr("jz_taken", 8'hA0, 1'b1, 1'b0);
        check("jz_pc_load_c5", obs_v, RAM_RD | PC_DIN);
        do_reset();
        run_instr("jz_untaken", 8'hA0, 1'b0, 1'b0);
        check("jz_skip_c3", obs_v, PC_CNT);
        tick();
        check("jz_refetch_c4", obs_v, PC2MAR);

        // HLT: halted from cycle 4 on, i_run ignored; reset clears it.
        do_reset();
        run_instr("hlt_cycle", 8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom_range(0, 1));
            tick();
            check("hlt_halted", 32'(obs_halted), 32'd1);
            check("hlt_idle", obs_v, IDLE);
            check("hlt_nofault", 32'(obs_fault), 32'd0);
        end
        do_reset();
        tick();
        check("hlt_reset_clears", 32'(obs_halted), 32'd0);

        // Overflow: ignored without a count, fatal during FETCH1.
        do_reset();
        ir = 8'h00;
        run = 1'b1;
        pc_of = 1'b1;
        tick();
        check("of_fetch0_vec", obs_v, PC2MAR);
        tick();
        check("of_fetch1_vec", obs_v, FETCHI);
        pc_of = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("of_halted", 32'(obs_halted), 32'd1);
            check("of_fault", 32'(obs_fault), 32'd1);
            check("of_idle", obs_v, IDLE);
        end
        do_reset();
        tick();
        check("of_reset_fault", 32'(obs_fault), 32'd0);

        // Overflow on the untaken-branch skip count.
        do_reset();
        ir = 8'hA0;
        zr = 1'b0;
        run = 1'b1;
        tick();
        tick();
        pc_of = 1'b1;
        tick();
        check("of_skip_vec", obs_v, PC_CNT);
        pc_of = 1'b0;
        tick();
        check("of_skip_halted", 32'(obs_halted), 32'd1);
        check("of_skip_fault", 32'(obs_fault), 32'd1);

        // Reset in the middle of an LDA with i_run held high.
        do_reset();
        ir = 8'h10;
        run = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        check("midrst_idle", active(), IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("midrst_fetch0", obs_v, PC2MAR);
        tick();
        check("midrst_fetch1", obs_v, FETCHI);

        // Randomized instruction stream; flags and i_run matter only where sampled.
        do_reset();
        exp_alu = 4'h0;
        exp_cin = 1'b0;
        for (int n = 0; n < 300; n++) begin
            op  = 4'($urandom_range(0, 14));
            z   = 1'($urandom_range(0, 1));
            c   = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                run = 1'b0;
                tick();
                check("rand_gap_idle", obs_v, IDLE);
            end
            ir = {op, 4'($urandom)};
            expand(op, z, c, q);
            for (int i = 0; i < q.size(); i++) begin
                run = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                zr  = (i == 2) ? z : 1'($urandom_range(0, 1));
                co  = (i == 2) ? c : 1'($urandom_range(0, 1));
                tick();
                if (i == 3 && op inside {[4'h4:4'h8]}) begin
                    exp_alu = alu_exp(op);
                    exp_cin = (op == 4'h5);
                end
                check($sformatf("rand_vec_op%0h_c%0d", op, i), obs_v, q[i]);
                check("rand_aluop", 32'(obs_alu), 32'(exp_alu));
                check("rand_cin", 32'(obs_cin), 32'(exp_cin));
                check("rand_halted", 32'(obs_halted), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
